// File: rtl/corr_readout_if.sv
// corr_readout_if: dump request, correlator result port and byte-stream handshake.
interface corr_readout_if;
    logic        dumpReq;
    logic        busy;
    logic        done;
    logic        read;
    logic [15:0] RamAddr;
    logic [31:0] RamData;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    modport master (
        input  dumpReq, RamData, txReady,
        output busy, done, read, RamAddr, txData, txValid
    );
    modport slave (
        output dumpReq, RamData, txReady,
        input  busy, done, read, RamAddr, txData, txValid
    );
endinterface

// File: rtl/corr_readout.sv
// corr_readout: walks the five correlator banks and streams the result set
// as a framed byte stream (header, MSB-first words, additive checksum).
module corr_readout #(
    parameter int         READ_LAT = 2,
    parameter logic [7:0] HDR0     = 8'hA5,
    parameter logic [7:0] HDR1     = 8'h5A
) (
    input logic            clk,
    input logic            rst_n,
    corr_readout_if.master bus
);
    typedef enum logic [2:0] {IDLE, HDR, WAIT, SEND, NEXT, CSUM} state_t;
    state_t      state;
    logic [23:0] shreg;
    logic [7:0]  csum;
    logic [1:0]  idx;
    logic [2:0]  wcnt;
    logic [11:0] lim;
    logic [15:0] next_addr;
    logic        acc;
    assign acc = bus.txValid && bus.txReady;
    // bank n (upper nibble) holds 32 << (n-1) words
    always_comb begin
        lim = (bus.RamAddr[15:12] == 4'h1) ? 12'h01F :
              (bus.RamAddr[15:12] == 4'h2) ? 12'h03F :
              (bus.RamAddr[15:12] == 4'h3) ? 12'h07F :
              (bus.RamAddr[15:12] == 4'h4) ? 12'h0FF : 12'h1FF;
        next_addr = (bus.RamAddr[11:0] == lim) ? {bus.RamAddr[15:12] + 4'h1, 12'h000}
                                               : bus.RamAddr + 16'h0001;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            csum        <= '0;
            idx         <= '0;
            wcnt        <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.read    <= 1'b0;
            bus.RamAddr <= '0;
            bus.txData  <= '0;
            bus.txValid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.dumpReq && !bus.done) begin
                    state       <= HDR;
                    bus.busy    <= 1'b1;
                    bus.read    <= 1'b1;
                    bus.RamAddr <= 16'h1000;
                    csum        <= '0;
                    idx         <= '0;
                    bus.txValid <= 1'b1;
                    bus.txData  <= HDR0;
                end
                HDR: if (acc) begin
                    if (idx == 2'd0) begin
                        idx        <= 2'd1;
                        bus.txData <= HDR1;
                    end else begin
                        bus.txValid <= 1'b0;
                        wcnt        <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: if (wcnt == 3'(READ_LAT - 1)) begin
                    shreg       <= bus.RamData[23:0];
                    bus.txData  <= bus.RamData[31:24];
                    bus.txValid <= 1'b1;
                    idx         <= '0;
                    state       <= SEND;
                end else begin
                    wcnt <= wcnt + 3'd1;
                end
                SEND: if (acc) begin
                    csum  <= csum + bus.txData;
                    idx   <= idx + 2'd1;
                    shreg <= {shreg[15:0], 8'h00};
                    if (idx == 2'd3) begin
                        bus.txValid <= 1'b0;
                        state       <= NEXT;
                    end else begin
                        bus.txData <= shreg[23:16];
                    end
                end
                NEXT: begin
                    wcnt <= '0;
                    if (bus.RamAddr == 16'h51FF) begin
                        bus.txData  <= csum;
                        bus.txValid <= 1'b1;
                        state       <= CSUM;
                    end else begin
                        bus.RamAddr <= next_addr;
                        state       <= WAIT;
                    end
                end
                CSUM: if (acc) begin
                    bus.txValid <= 1'b0;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    bus.read    <= 1'b0;
                    bus.RamAddr <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_corr_readout.sv
// tb_corr_readout: directed frame, address-trace, backpressure, latency,
// request-filtering and mid-dump reset scenarios for corr_readout.
module tb_corr_readout;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    corr_readout_if b0 ();
    corr_readout_if b1 ();
    corr_readout #(.READ_LAT(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    corr_readout #(.READ_LAT(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: data valid only once the address has been stable READ_LAT-1 edges
    logic [15:0] p0 = '0, p1 = '0;
    int a0 = 0, a1 = 0;
    always @(posedge clk) begin
        a0 <= (b0.RamAddr != p0) ? 1 : (a0 < 100 ? a0 + 1 : a0);
        p0 <= b0.RamAddr;
        a1 <= (b1.RamAddr != p1) ? 1 : (a1 < 100 ? a1 + 1 : a1);
        p1 <= b1.RamAddr;
    end
    assign b0.RamData = (b0.RamAddr == p0 && a0 >= 1) ? {16'hC0DE, b0.RamAddr} : 32'hDEADBEEF;
    assign b1.RamData = (b1.RamAddr == p1 && a1 >= 3) ? {16'hC0DE, b1.RamAddr} : 32'hDEADBEEF;

    logic [7:0]  q0[$], q1[$], expq[$];
    logic [15:0] addrs[$];
    int rises0[$], rises1[$];
    int done0 = 0, done1 = 0, stab0 = 0, rdlow = 0;
    logic pv0 = 0, pacc0 = 0, prst = 0, pv1 = 0;
    logic [7:0] pd0 = '0;
    logic [15:0] la = '0;
    always @(negedge clk) begin
        if (b0.txValid && b0.txReady) q0.push_back(b0.txData);
        if (rst_n && prst && pv0 && !pacc0 && (b0.txValid !== 1'b1 || b0.txData !== pd0)) stab0++;
        if (b0.txValid && !pv0) rises0.push_back(cyc);
        if (b0.done) done0++;
        if (b0.read && b0.RamAddr != la) addrs.push_back(b0.RamAddr);
        if (b0.busy && !b0.read) rdlow++;
        la = b0.RamAddr;
        pv0 = b0.txValid;
        pd0 = b0.txData;
        pacc0 = b0.txValid && b0.txReady;
        prst = rst_n;
        if (b1.txValid && b1.txReady) q1.push_back(b1.txData);
        if (b1.txValid && !pv1) rises1.push_back(cyc);
        if (b1.done) done1++;
        pv1 = b1.txValid;
    end

    // index of first difference against the reference frame, -1 if identical
    function automatic int fdiff(input logic [7:0] q[$]);
        if (q.size() != expq.size()) return q.size();
        for (int i = 0; i < q.size(); i++) if (q[i] !== expq[i]) return i;
        return -1;
    endfunction

    task automatic run(input bit sel, input bit bp);
        int n = 0;
        int d = sel ? done1 : done0;
        if (sel) begin q1.delete(); rises1.delete(); end
        else begin q0.delete(); addrs.delete(); rises0.delete(); end
        @(posedge clk); #1;
        if (sel) b1.dumpReq = 1'b1; else b0.dumpReq = 1'b1;
        @(posedge clk); #1;
        b0.dumpReq = 1'b0;
        b1.dumpReq = 1'b0;
        while ((sel ? done1 : done0) == d && n < 30000) begin
            b0.txReady = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        b0.txReady = 1'b1;
        n_cmp++;
        if (n >= 30000) begin n_bad++; $display("FAIL run_timeout: got %0d cycles want < 30000", n); end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({b0.busy, b0.done, b0.read, b0.txValid} !== 4'b0) begin n_bad++; $display("FAIL reset_flags0: got %b want 0000", {b0.busy, b0.done, b0.read, b0.txValid}); end
        n_cmp++;
        if (b0.RamAddr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr0: got %h want 0000", b0.RamAddr); end
        n_cmp++;
        if (b0.txData !== 8'h00) begin n_bad++; $display("FAIL reset_data0: got %h want 00", b0.txData); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({b1.busy, b1.done, b1.read, b1.txValid, b1.RamAddr, b1.txData} !== 28'h0) begin n_bad++; $display("FAIL reset_idle1: got %h want 0", {b1.busy, b1.done, b1.read, b1.txValid, b1.RamAddr, b1.txData}); end
    endtask

    task automatic test_full_dump;
        bit seen = 0;
        run(0, 0);
        n_cmp++;
        if (q0.size() !== 3971) begin n_bad++; $display("FAIL frame_len: got %0d want 3971", q0.size()); end
        if (q0.size() == 3971) begin
            n_cmp++;
            if ({q0[0], q0[1]} !== 16'hA55A) begin n_bad++; $display("FAIL header: got %h want a55a", {q0[0], q0[1]}); end
            n_cmp++;
            if ({q0[2], q0[3], q0[4], q0[5]} !== 32'hC0DE1000) begin n_bad++; $display("FAIL word0: got %h want c0de1000", {q0[2], q0[3], q0[4], q0[5]}); end
            n_cmp++;
            if ({q0[3966], q0[3967], q0[3968], q0[3969]} !== 32'hC0DE51FF) begin n_bad++; $display("FAIL last_word: got %h want c0de51ff", {q0[3966], q0[3967], q0[3968], q0[3969]}); end
            n_cmp++;
            if (q0[3970] !== 8'h50) begin n_bad++; $display("FAIL checksum: got %h want 50", q0[3970]); end
        end
        n_cmp++;
        if (fdiff(q0) != -1) begin n_bad++; $display("FAIL frame_full: got diff at %0d want none", fdiff(q0)); end
        n_cmp++;
        if (done0 !== 1) begin n_bad++; $display("FAIL done_once: got %0d want 1", done0); end
        n_cmp++;
        if (addrs.size() !== 992) begin n_bad++; $display("FAIL addr_count: got %0d want 992", addrs.size()); end
        for (int i = 0; i + 1 < addrs.size(); i++) if (addrs[i] == 16'h101F && addrs[i+1] == 16'h2000) seen = 1;
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL addr_bank_jump: got missing want 101f->2000"); end
        n_cmp++;
        if (addrs.size() == 0 || addrs[addrs.size()-1] !== 16'h51FF) begin n_bad++; $display("FAIL addr_last: got %0d entries want last 51ff", addrs.size()); end
        n_cmp++;
        if (rdlow !== 0) begin n_bad++; $display("FAIL read_high: got %0d low cycles want 0", rdlow); end
        n_cmp++;
        if (rises0.size() < 3 || rises0[2] - rises0[1] !== 7) begin n_bad++; $display("FAIL word_period2: got %0d want 7", rises0.size() < 3 ? -1 : rises0[2] - rises0[1]); end
        n_cmp++;
        if ({b0.busy, b0.read, b0.txValid, b0.RamAddr} !== 19'h0) begin n_bad++; $display("FAIL idle_after: got %h want 0", {b0.busy, b0.read, b0.txValid, b0.RamAddr}); end
    endtask

    task automatic test_backpressure;
        stab0 = 0;
        run(0, 1);
        n_cmp++;
        if (fdiff(q0) != -1) begin n_bad++; $display("FAIL bp_frame: got diff at %0d want none", fdiff(q0)); end
        n_cmp++;
        if (stab0 !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d violations want 0", stab0); end
        n_cmp++;
        if (done0 !== 2) begin n_bad++; $display("FAIL bp_done: got %0d want 2", done0); end
    endtask

    task automatic test_read_lat4;
        run(1, 0);
        n_cmp++;
        if (fdiff(q1) != -1) begin n_bad++; $display("FAIL lat4_frame: got diff at %0d want none", fdiff(q1)); end
        n_cmp++;
        if (rises1.size() < 3 || rises1[2] - rises1[1] !== 9) begin n_bad++; $display("FAIL lat4_period: got %0d want 9", rises1.size() < 3 ? -1 : rises1[2] - rises1[1]); end
        n_cmp++;
        if (done1 !== 1) begin n_bad++; $display("FAIL lat4_done: got %0d want 1", done1); end
    endtask

    // dumpReq held high for the whole frame, including the done cycle
    task automatic test_back_to_back;
        int n = 0;
        int d = done0;
        q0.delete();
        @(posedge clk); #1;
        b0.dumpReq = 1'b1;
        while (done0 == d && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        b0.dumpReq = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (done0 - d !== 1 || b0.busy !== 1'b0) begin n_bad++; $display("FAIL held_req_single: got done %0d busy %b want 1 0", done0 - d, b0.busy); end
        n_cmp++;
        if (fdiff(q0) != -1) begin n_bad++; $display("FAIL held_req_frame: got diff at %0d want none", fdiff(q0)); end
        run(0, 0);
        n_cmp++;
        if (fdiff(q0) != -1 || done0 - d !== 2) begin n_bad++; $display("FAIL second_frame: got diff %0d done %0d want -1 2", fdiff(q0), done0 - d); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int d = done0;
        q0.delete();
        @(posedge clk); #1;
        b0.dumpReq = 1'b1;
        @(posedge clk); #1;
        b0.dumpReq = 1'b0;
        while (b0.RamAddr != 16'h3000 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n >= 5000) begin n_bad++; $display("FAIL reach_bank_c: got %h want 3000", b0.RamAddr); end
        repeat (20) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({b0.busy, b0.done, b0.read, b0.txValid, b0.RamAddr, b0.txData} !== 28'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0", {b0.busy, b0.done, b0.read, b0.txValid, b0.RamAddr, b0.txData}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done0 !== d || b0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_done: got done %0d busy %b want %0d 0", done0, b0.busy, d); end
        run(0, 0);
        n_cmp++;
        if (fdiff(q0) != -1 || done0 - d !== 1) begin n_bad++; $display("FAIL after_reset_frame: got diff %0d done %0d want -1 1", fdiff(q0), done0 - d); end
    endtask

    initial begin
        logic [7:0] s = '0;
        b0.dumpReq = 1'b0; b0.txReady = 1'b1;
        b1.dumpReq = 1'b0; b1.txReady = 1'b1;
        expq.push_back(8'hA5);
        expq.push_back(8'h5A);
        for (int b = 1; b <= 5; b++) begin
            for (int o = 0; o < (32 << (b - 1)); o++) begin
                logic [15:0] a;
                a = 16'(b * 4096 + o);
                expq.push_back(8'hC0); expq.push_back(8'hDE);
                expq.push_back(a[15:8]); expq.push_back(a[7:0]);
                s = s + 8'hC0 + 8'hDE + a[15:8] + a[7:0];
            end
        end
        expq.push_back(s);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_read_lat4();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
